// File: rtl/systolic_sequencer.sv
// Control sequencer for an NxN systolic array: fills the input memory from an AXIS slave,
// loads weights, streams operands, waits out the array pipeline and drains results to an AXIS master.
module systolic_sequencer #(
  parameter int ARRAY_SIZE   = 2,
  parameter int ADDR_WIDTH   = 1,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  interrupt,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  input  logic                  m_tready,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  load_weights,
  output logic [ADDR_WIDTH-1:0] e_rd_addr,
  output logic                  valid_in,
  output logic [ADDR_WIDTH-1:0] abcd_rd_addr,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_wr_addr,
  output logic [ADDR_WIDTH-1:0] out_rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  abort_pulse,
  output logic                  len_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_SEND
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ARRAY_SIZE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    cnt_last;
  logic [PIPE_LATENCY-1:0] vld_sr;
  logic [ADDR_WIDTH-1:0]   addr_sr [PIPE_LATENCY];

  assign cnt_last = (cnt == LAST);

  // Strobes are pure decodes of the registered state and counter, so they drop
  // the instant reset asserts; fill_en alone follows s_tvalid combinationally.
  assign s_tready     = (state == S_FILL);
  assign fill_en      = s_tready && s_tvalid;
  assign fill_addr    = s_tready ? cnt : '0;
  assign load_weights = (state == S_LOAD);
  assign e_rd_addr    = load_weights ? cnt : '0;
  assign valid_in     = (state == S_RUN);
  assign abcd_rd_addr = valid_in ? cnt : '0;
  assign m_tvalid     = (state == S_SEND);
  assign m_tlast      = m_tvalid && cnt_last;
  assign out_rd_addr  = m_tvalid ? cnt : '0;
  assign busy         = (state != S_IDLE);
  assign out_wr_en    = vld_sr[PIPE_LATENCY-1];
  assign out_wr_addr  = addr_sr[PIPE_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      len_err     <= 1'b0;
      done        <= 1'b0;
      abort_pulse <= 1'b0;
      vld_sr      <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) addr_sr[i] <= '0;
    end else begin
      done        <= 1'b0;
      abort_pulse <= 1'b0;
      vld_sr[0]   <= valid_in;
      addr_sr[0]  <= abcd_rd_addr;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end

      // An abort overrides everything below, including the pipeline shift above.
      if (interrupt && state != S_IDLE) begin
        state       <= S_IDLE;
        cnt         <= '0;
        abort_pulse <= 1'b1;
        vld_sr      <= '0;
        for (int i = 0; i < PIPE_LATENCY; i++) addr_sr[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_FILL;
              cnt     <= '0;
              len_err <= 1'b0;
            end
          end
          S_FILL: begin
            if (s_tvalid) begin
              if (s_tlast != cnt_last) len_err <= 1'b1;
              if (s_tlast || cnt_last) begin
                state <= S_LOAD;
                cnt   <= '0;
              end else begin
                cnt <= cnt + ADDR_WIDTH'(1);
              end
            end
          end
          S_LOAD: begin
            if (cnt_last) begin
              state <= S_RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
          S_RUN: begin
            if (cnt_last) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
          S_WAIT: begin
            if (out_wr_en && out_wr_addr == LAST) begin
              state <= S_SEND;
              cnt   <= '0;
            end
          end
          S_SEND: begin
            if (m_tready) begin
              if (cnt_last) begin
                state <= S_IDLE;
                cnt   <= '0;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + ADDR_WIDTH'(1);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer (N=2, latency 3): strobe windows are checked every
// cycle and result writes, master beats and done pulses are matched against a scoreboard.
module tb_systolic_sequencer;

  localparam int N  = 2;
  localparam int L  = 3;
  localparam int AW = 1;

  logic clk, rst, start, interrupt, s_tvalid, s_tlast, m_tready;
  logic s_tready, m_tvalid, m_tlast, fill_en, load_weights, valid_in, out_wr_en;
  logic busy, done, abort_pulse, len_err;
  logic [AW-1:0] fill_addr, e_rd_addr, abcd_rd_addr, out_wr_addr, out_rd_addr;

  typedef struct {
    int   cyc;
    int   addr;
    logic last;
  } ev_t;

  ev_t  wr_q[$];
  ev_t  tx_q[$];
  int   done_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc, load_lo, run_lo, stall_lo, stall_hi, abort_cyc, fill_idx;
  logic exp_fill;

  systolic_sequencer #(
    .ARRAY_SIZE  (N),
    .ADDR_WIDTH  (AW),
    .PIPE_LATENCY(L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .interrupt   (interrupt),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tready    (m_tready),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .fill_en     (fill_en),
    .fill_addr   (fill_addr),
    .load_weights(load_weights),
    .e_rd_addr   (e_rd_addr),
    .valid_in    (valid_in),
    .abcd_rd_addr(abcd_rd_addr),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_rd_addr (out_rd_addr),
    .busy        (busy),
    .done        (done),
    .abort_pulse (abort_pulse),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic stalled(input int c);
    return (c >= stall_lo) && (c <= stall_hi);
  endfunction

  // Expected timeline for one job: writes trail the RUN window by L cycles,
  // SEND opens the cycle after the last write, each beat waits out any stall.
  task automatic push_job();
    int c;
    for (int i = 0; i < N; i++) wr_q.push_back('{run_lo + L + i, i, 1'b0});
    c = run_lo + N + L;
    for (int i = 0; i < N; i++) begin
      while (stalled(c)) c++;
      tx_q.push_back('{c, i, (i == N - 1)});
      c++;
    end
    done_q.push_back(c);
  endtask

  task automatic begin_job(input int lo, input int s_lo, input int s_hi, input bit expect_results);
    cyc       = 0;
    fill_idx  = 0;
    load_lo   = lo;
    run_lo    = lo + N;
    stall_lo  = s_lo;
    stall_hi  = s_hi;
    abort_cyc = -1;
    if (expect_results) push_job();
  endtask

  task automatic check_output();
    logic in_load, in_run;
    ev_t  e;
    check_bit("fill_en", fill_en, exp_fill);
    if (exp_fill) begin
      check_val("fill_addr", int'(fill_addr), fill_idx);
      fill_idx++;
    end
    in_load = (cyc >= load_lo) && (cyc < load_lo + N);
    check_bit("load_weights", load_weights, in_load);
    if (in_load) check_val("e_rd_addr", int'(e_rd_addr), cyc - load_lo);
    in_run = (cyc >= run_lo) && (cyc < run_lo + N);
    check_bit("valid_in", valid_in, in_run);
    if (in_run) check_val("abcd_rd_addr", int'(abcd_rd_addr), cyc - run_lo);
    check_bit("abort_pulse", abort_pulse, cyc == abort_cyc);
    if (out_wr_en) begin
      if (wr_q.size() == 0) check_bit("wr_unexpected", out_wr_en, 1'b0);
      else begin
        e = wr_q.pop_front();
        check_val("wr_cycle", cyc, e.cyc);
        check_val("wr_addr", int'(out_wr_addr), e.addr);
      end
    end
    if (m_tvalid) begin
      if (tx_q.size() == 0) check_bit("tx_unexpected", m_tvalid, 1'b0);
      else begin
        e = tx_q[0];
        check_val("tx_addr", int'(out_rd_addr), e.addr);
        check_bit("tx_last", m_tlast, e.last);
        if (m_tready) begin
          check_val("tx_cycle", cyc, e.cyc);
          void'(tx_q.pop_front());
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) check_bit("done_unexpected", done, 1'b0);
      else check_val("done_cycle", cyc, done_q.pop_front());
    end
  endtask

  // Inputs for the current cycle are driven 1ns after the rising edge and sampled 1ns later.
  task automatic apply_stimulus(input logic st, input logic tv, input logic tl,
                                input logic irq, input logic ef);
    start     = st;
    s_tvalid  = tv;
    s_tlast   = tl;
    interrupt = irq;
    exp_fill  = ef;
    m_tready  = !stalled(cyc);
    #1;
    check_output();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_wr_left"}, wr_q.size(), 0);
    check_val({tag, "_tx_left"}, tx_q.size(), 0);
    check_val({tag, "_done_left"}, done_q.size(), 0);
    check_bit({tag, "_busy_end"}, busy, 1'b0);
  endtask

  task automatic run_nominal(input string tag);
    begin_job(3, -1, -2, 1);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 1, 1, 0, 1);
    repeat (11) apply_stimulus(0, 0, 0, 0, 0);
    check_bit({tag, "_len_err"}, len_err, 1'b0);
    check_drained(tag);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; interrupt = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    exp_fill = 1'b0; load_lo = -100; run_lo = -100; stall_lo = -1; stall_hi = -2;
    abort_cyc = -1; cyc = 0; fill_idx = 0;

    $display("[TB] reset state");
    #2;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_s_tready", s_tready, 1'b0);
    check_bit("rst_m_tvalid", m_tvalid, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_len_err", len_err, 1'b0);
    check_bit("rst_out_wr_en", out_wr_en, 1'b0);
    repeat (2) apply_stimulus(1, 0, 0, 0, 0);
    check_bit("rst_start_ignored", busy, 1'b0);
    rst = 1'b1;
    repeat (2) apply_stimulus(0, 0, 0, 0, 0);
    check_bit("post_rst_idle", busy, 1'b0);

    $display("[TB] nominal job");
    run_nominal("nominal");

    $display("[TB] master backpressure");
    begin_job(3, 10, 13, 1);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 1, 1, 0, 1);
    repeat (15) apply_stimulus(0, 0, 0, 0, 0);
    check_drained("backpressure");

    $display("[TB] slave bubble");
    begin_job(4, -1, -2, 1);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 0, 1);
    repeat (12) apply_stimulus(0, 0, 0, 0, 0);
    check_bit("bubble_len_err", len_err, 1'b0);
    check_drained("bubble");

    $display("[TB] early tlast");
    begin_job(2, -1, -2, 1);
    apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(0, 1, 1, 0, 1);
    check_bit("early_len_err", len_err, 1'b1);
    repeat (11) apply_stimulus(0, 0, 0, 0, 0);
    check_bit("early_len_err_sticky", len_err, 1'b1);
    check_drained("early");

    $display("[TB] interrupt during RUN");
    begin_job(3, -1, -2, 0);
    abort_cyc = 7;
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    check_bit("restart_len_err_cleared", len_err, 1'b0);
    apply_stimulus(0, 1, 1, 0, 1);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 1, 0);
    check_bit("abort_idle", busy, 1'b0);
    repeat (8) apply_stimulus(0, 0, 0, 0, 0);
    check_drained("abort");
    run_nominal("after_abort");

    $display("[TB] reset mid-job");
    begin_job(3, -1, -2, 1);
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 1, 1, 0, 1);
    repeat (6) apply_stimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_bit("async_busy", busy, 1'b0);
    check_bit("async_out_wr_en", out_wr_en, 1'b0);
    check_val("async_out_wr_addr", int'(out_wr_addr), 0);
    check_bit("async_m_tvalid", m_tvalid, 1'b0);
    check_bit("async_valid_in", valid_in, 1'b0);
    check_bit("async_done", done, 1'b0);
    wr_q.delete();
    tx_q.delete();
    done_q.delete();
    load_lo = -100;
    run_lo  = -100;
    repeat (2) apply_stimulus(1, 0, 0, 0, 0);
    check_bit("reset_start_ignored", busy, 1'b0);
    rst = 1'b1;
    repeat (2) apply_stimulus(0, 0, 0, 0, 0);
    check_bit("no_resume", busy, 1'b0);
    run_nominal("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 2, meaning array dimension N and the depth of every input and output memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1, meaning memory address width; it equals max(1, ceil(log2(ARRAY_SIZE))).
REQ-003 SHALL have parameter PIPE_LATENCY, default 3, meaning the number of cycles from valid_in to the matching array output (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a job; honoured only in IDLE.
REQ-007 SHALL have port interrupt, input, 1 bit: synchronous abort.
REQ-008 SHALL have ports s_tvalid (input, 1), s_tlast (input, 1) and s_tready (output, 1): the AXIS slave handshake.
REQ-009 SHALL have ports m_tready (input, 1), m_tvalid (output, 1) and m_tlast (output, 1): the AXIS master handshake.
REQ-010 SHALL have ports fill_en (output, 1) and fill_addr (output, ADDR_WIDTH): the input-memory write controls.
REQ-011 SHALL have ports load_weights (output, 1) and e_rd_addr (output, ADDR_WIDTH): the weight-load controls.
REQ-012 SHALL have ports valid_in (output, 1) and abcd_rd_addr (output, ADDR_WIDTH): the array feed controls.
REQ-013 SHALL have ports out_wr_en (output, 1) and out_wr_addr (output, ADDR_WIDTH): the result-memory write controls.
REQ-014 SHALL have port out_rd_addr, output, ADDR_WIDTH: the result-memory read address.
REQ-015 SHALL have ports busy, done, abort_pulse and len_err, each output, 1 bit: status.

Function
REQ-016 SHALL implement the states IDLE, FILL, LOAD, RUN, WAIT and SEND, with a shared counter cnt that is cleared on every state entry.
REQ-017 SHALL behave as follows in IDLE: start=1 -> FILL on the next cycle; all strobes are 0.
REQ-018 SHALL behave as follows in FILL:
- s_tready=1.
- fill_en = s_tvalid and fill_addr = cnt.
- Each accepted beat increments cnt.
- An accepted beat with s_tlast=1 or with cnt==N-1 -> LOAD.
REQ-019 SHALL set len_err (sticky until the next start) when s_tlast=1 at cnt<N-1, or when s_tlast=0 at cnt==N-1; the LOAD transition still occurs.
REQ-020 SHALL behave as follows in LOAD: load_weights=1 and e_rd_addr=cnt for exactly N cycles, then -> RUN.
REQ-021 SHALL behave as follows in RUN: valid_in=1 and abcd_rd_addr=cnt for exactly N cycles, then -> WAIT.
REQ-022 SHALL drive out_wr_en and out_wr_addr as valid_in and abcd_rd_addr delayed by exactly PIPE_LATENCY cycles, through a shift register.
REQ-023 SHALL leave WAIT for SEND on the cycle after the final out_wr_en=1 (the write to address N-1).
REQ-024 SHALL behave as follows in SEND:
- m_tvalid=1, out_rd_addr=cnt, m_tlast=(cnt==N-1).
- cnt increments only when m_tvalid and m_tready are both 1.
- The handshake with m_tlast=1 -> IDLE, and done=1 for one cycle in the following cycle.
REQ-025 SHALL hold out_rd_addr, m_tvalid and m_tlast stable while m_tready=0.
REQ-026 SHALL treat result-memory reads as combinational, so the data presented on the master stream matches out_rd_addr in the same cycle.
REQ-027 SHALL drive busy=1 in every state other than IDLE.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL, when interrupt=1 in any state other than IDLE, go to IDLE on the next cycle, clear cnt and the delay shift register, and pulse abort_pulse=1 for one cycle.
REQ-030 SHALL let interrupt take priority over start and over every handshake in the same cycle; interrupt in IDLE has no effect.
REQ-031 SHALL wrap cnt to 0 at state change and never index at or beyond N.

Reset
REQ-032 SHALL, while rst=0, asynchronously force the state to IDLE and force cnt, the shift register, len_err and every output to 0.
REQ-033 SHALL, on reset deassertion mid-job, restart only on a new start; no partial job resumes.

Verification (N=2, PIPE_LATENCY=3, start pulsed at cycle 0)
REQ-034 SHALL cover the nominal job: s_tvalid held 1 with s_tlast on the 2nd beat, m_tready=1 -> fill_en at cycles 1-2, load_weights at 3-4, valid_in at 5-6, out_wr_en at 8-9 (addresses 0,1), m_tvalid at 10-11 with m_tlast at 11, done at 12, len_err=0.
REQ-035 SHALL cover master backpressure: m_tready=0 during cycles 10-13 -> out_rd_addr holds 0 and m_tvalid holds 1; beats complete at cycles 14-15; done at 16.
REQ-036 SHALL cover a slave bubble: s_tvalid=0 at cycle 2 -> the 2nd write occurs at cycle 3 and LOAD starts at cycle 4.
REQ-037 SHALL cover an early tlast: s_tlast=1 on the 1st beat -> len_err=1 and LOAD starts at cycle 2.
REQ-038 SHALL cover interrupt: interrupt=1 at cycle 6 -> IDLE at cycle 7, abort_pulse at 7, and no out_wr_en ever asserts; a subsequent start runs a clean job.
REQ-039 SHALL cover reset: rst=0 asserted at cycle 9 -> all outputs 0 immediately (asynchronously); start is ignored while rst=0.
